// File: rtl/circ_window_counter_pkg.sv
// rtl/circ_window_counter_pkg.sv - shared width helper and command encoding for circ_window_counter
package circ_window_counter_pkg;

  // Index width never drops below one bit, even for tiny moduli.
  function automatic int cwc_idx_w(input int m);
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

  typedef enum logic [1:0] {
    CMD_HOLD = 2'd0,
    CMD_INC  = 2'd1,
    CMD_DEC  = 2'd2,
    CMD_LD   = 2'd3
  } cmd_e;

endpackage

// File: rtl/circ_window_counter_mod_step.sv
// rtl/circ_window_counter_mod_step.sv - combinational (idx +/- 1) mod MOD step
module mod_step
  import circ_window_counter_pkg::*;
#(
  parameter int MOD   = 5,
  parameter int IDX_W = cwc_idx_w(MOD)
) (
  input  logic [IDX_W-1:0] idx,
  input  logic             up,
  output logic [IDX_W-1:0] res
);

  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(MOD - 1);

  // Compare-to-bound instead of a modulo so the step stays a single adder.
  always_comb begin
    res = '0;
    if (up) begin
      res = (idx == IDX_MAX) ? '0 : idx + IDX_W'(1);
    end else begin
      res = (idx == '0) ? IDX_MAX : idx - IDX_W'(1);
    end
  end

endmodule

// File: rtl/circ_window_counter.sv
// rtl/circ_window_counter.sv - circular index counter with registered prev/cur/next window
module circ_window_counter
  import circ_window_counter_pkg::*;
#(
  parameter int MOD   = 5,
  parameter int IDX_W = cwc_idx_w(MOD),
  parameter int LAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             ld,
  input  logic [IDX_W-1:0] ld_val,
  output logic [IDX_W-1:0] prev,
  output logic [IDX_W-1:0] cur,
  output logic [IDX_W-1:0] next,
  output logic             wrap,
  output logic             ld_err,
  output logic [LAP_W-1:0] lap_cnt
);

  localparam int               IDX_W1  = IDX_W + 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(MOD - 1);
  localparam logic [IDX_W:0]   MOD_V   = IDX_W1'(MOD);

  cmd_e             cmd;
  logic             ld_ok;
  logic [IDX_W-1:0] next_next, prev_prev, ld_next, ld_prev;

  mod_step #(.MOD(MOD), .IDX_W(IDX_W)) u_nn  (.idx(next),   .up(1'b1), .res(next_next));
  mod_step #(.MOD(MOD), .IDX_W(IDX_W)) u_pp  (.idx(prev),   .up(1'b0), .res(prev_prev));
  mod_step #(.MOD(MOD), .IDX_W(IDX_W)) u_ldn (.idx(ld_val), .up(1'b1), .res(ld_next));
  mod_step #(.MOD(MOD), .IDX_W(IDX_W)) u_ldp (.idx(ld_val), .up(1'b0), .res(ld_prev));

  // Simultaneous inc and dec cancel out and fall through to hold.
  always_comb begin
    cmd   = CMD_HOLD;
    ld_ok = ({1'b0, ld_val} < MOD_V);
    if (ld) begin
      cmd = CMD_LD;
    end else if (inc && !dec) begin
      cmd = CMD_INC;
    end else if (dec && !inc) begin
      cmd = CMD_DEC;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur     <= '0;
      prev    <= IDX_MAX;
      next    <= IDX_W'(1);
      wrap    <= 1'b0;
      ld_err  <= 1'b0;
      lap_cnt <= '0;
    end else begin
      wrap   <= 1'b0;
      ld_err <= 1'b0;
      case (cmd)
        CMD_INC: begin
          prev <= cur;
          cur  <= next;
          next <= next_next;
          if (cur == IDX_MAX) begin
            wrap    <= 1'b1;
            lap_cnt <= lap_cnt + LAP_W'(1);
          end
        end
        CMD_DEC: begin
          next <= cur;
          cur  <= prev;
          prev <= prev_prev;
          if (cur == '0) begin
            wrap    <= 1'b1;
            lap_cnt <= lap_cnt - LAP_W'(1);
          end
        end
        CMD_LD: begin
          if (ld_ok) begin
            cur  <= ld_val;
            prev <= ld_prev;
            next <= ld_next;
          end else begin
            ld_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
